// File: rtl/hamming74_pkg.sv
// Shared constants for the Hamming(7,4) decoder: widths, FSM states and the
// syndrome values that identify each codeword bit position.
package hamming74_pkg;

    localparam int unsigned CW_WIDTH   = 7;
    localparam int unsigned DATA_WIDTH = 4;
    localparam int unsigned SYN_WIDTH  = 3;
    localparam int unsigned CNT_WIDTH  = 8;

    typedef enum logic [1:0] {
        StIdle,
        StRecv,
        StCheck,
        StDone
    } state_e;

    typedef logic [SYN_WIDTH-1:0] syn_t;

    localparam syn_t SynNone = 3'b000;
    localparam syn_t SynP0   = 3'b001;
    localparam syn_t SynP1   = 3'b010;
    localparam syn_t SynP2   = 3'b100;
    localparam syn_t SynD0   = 3'b011;
    localparam syn_t SynD1   = 3'b101;
    localparam syn_t SynD2   = 3'b111;
    localparam syn_t SynD3   = 3'b110;

endpackage

// File: rtl/hamming_decoding_4bit_if.sv
// Serial-in / decoded-out bus of the Hamming(7,4) decoder.
interface hamming_decoding_4bit_if;
    import hamming74_pkg::*;

    logic                  start;
    logic                  din;
    logic                  ready;
    logic                  done;
    logic [DATA_WIDTH-1:0] dout;
    logic                  err;
    syn_t                  syndrome;
    logic [CNT_WIDTH-1:0]  err_count;

    modport master (
        output start, din,
        input  ready, done, dout, err, syndrome, err_count
    );

    modport slave (
        input  start, din,
        output ready, done, dout, err, syndrome, err_count
    );

endinterface

// File: rtl/hamming74_syndrome.sv
// Combinational Hamming(7,4) check: syndrome, single-bit corrected data and
// error flag for one 7-bit codeword {d3,d2,d1,d0,p2,p1,p0}.
module hamming74_syndrome
    import hamming74_pkg::*;
(
    input  logic [CW_WIDTH-1:0]   i_cw,
    output logic [DATA_WIDTH-1:0] o_data,
    output syn_t                  o_syndrome,
    output logic                  o_err
);

    logic [DATA_WIDTH-1:0] w_d;
    logic [2:0]            w_p;
    syn_t                  w_syn;

    assign w_d = i_cw[CW_WIDTH-1:3];
    assign w_p = i_cw[2:0];

    assign w_syn[0] = w_p[0] ^ w_d[0] ^ w_d[1] ^ w_d[2];
    assign w_syn[1] = w_p[1] ^ w_d[0] ^ w_d[2] ^ w_d[3];
    assign w_syn[2] = w_p[2] ^ w_d[1] ^ w_d[2] ^ w_d[3];

    // Parity-bit syndromes leave the data untouched; only data-bit syndromes flip.
    always_comb begin
        o_data = w_d;
        case (w_syn)
            SynD0:   o_data[0] = ~w_d[0];
            SynD1:   o_data[1] = ~w_d[1];
            SynD2:   o_data[2] = ~w_d[2];
            SynD3:   o_data[3] = ~w_d[3];
            default: o_data = w_d;
        endcase
    end

    assign o_syndrome = w_syn;
    assign o_err      = |w_syn;

endmodule

// File: rtl/hamming_decoding_4bit.sv
// Serial Hamming(7,4) decoder: receives cw[0]..cw[6] after start, corrects a
// single-bit error, then pulses done with the held result.
module hamming_decoding_4bit
    import hamming74_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    hamming_decoding_4bit_if.slave  bus
);

    state_e                r_state;
    state_e                w_state_next;
    logic [2:0]            r_cnt;
    logic [CW_WIDTH-1:0]   r_cw;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_err;
    syn_t                  r_syn;
    logic [CNT_WIDTH-1:0]  r_err_count;

    logic [DATA_WIDTH-1:0] w_data;
    syn_t                  w_syn;
    logic                  w_err;

    hamming74_syndrome u_syndrome (
        .i_cw       (r_cw),
        .o_data     (w_data),
        .o_syndrome (w_syn),
        .o_err      (w_err)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (bus.start) w_state_next = StRecv;
            StRecv:  if (r_cnt == 3'd6) w_state_next = StCheck;
            StCheck: w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt       <= 3'd0;
            r_cw        <= '0;
            r_dout      <= '0;
            r_err       <= 1'b0;
            r_syn       <= SynNone;
            r_err_count <= '0;
        end else begin
            if (r_state == StRecv) begin
                r_cw[r_cnt] <= bus.din;
                r_cnt       <= (r_cnt == 3'd6) ? 3'd0 : r_cnt + 3'd1;
            end
            if (r_state == StCheck) begin
                r_dout <= w_data;
                r_err  <= w_err;
                r_syn  <= w_syn;
                // Saturate rather than wrap so a noisy link never reads as clean.
                if (w_err && (r_err_count != '1)) begin
                    r_err_count <= r_err_count + 8'd1;
                end
            end
        end
    end

    assign bus.ready     = (r_state == StIdle);
    assign bus.done      = (r_state == StDone);
    assign bus.dout      = r_dout;
    assign bus.err       = r_err;
    assign bus.syndrome  = r_syn;
    assign bus.err_count = r_err_count;

endmodule

// File: tb/tb_hamming_decoding_4bit.sv
// Scoreboard bench for hamming_decoding_4bit: frames are built from data plus an
// injected flip; expected results come from the error position, not from decoding.
module tb_hamming_decoding_4bit;

    logic clk = 1'b0;
    logic rst;

    hamming_decoding_4bit_if bus ();

    hamming_decoding_4bit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] dout;
        logic       err;
        logic [2:0] syn;
        logic [7:0] cnt;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp     = 0;
    int   n_bad     = 0;
    int   cyc       = 0;
    int   model_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    function automatic logic [6:0] encode(input logic [3:0] d);
        logic p0, p1, p2;
        p0 = d[0] ^ d[1] ^ d[2];
        p1 = d[0] ^ d[2] ^ d[3];
        p2 = d[1] ^ d[2] ^ d[3];
        return {d, p2, p1, p0};
    endfunction

    // Syndrome the decoder must report for an error at codeword bit pos (7 = none).
    function automatic logic [2:0] syn_of(input int pos);
        case (pos)
            0:       return 3'b001;
            1:       return 3'b010;
            2:       return 3'b100;
            3:       return 3'b011;
            4:       return 3'b101;
            5:       return 3'b111;
            6:       return 3'b110;
            default: return 3'b000;
        endcase
    endfunction

    task automatic wait_ready();
        for (int i = 0; i < 30; i++) begin
            if (bus.ready) return;
            @(posedge clk);
            #1;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL ready_timeout: ready still %0d after 30 cycles, required 1", bus.ready);
    endtask

    task automatic send_frame(input logic [3:0] data, input int flip, input bit poke);
        logic [6:0] cw;
        exp_t       e;
        cw = encode(data);
        if (flip < 7) cw[flip] = ~cw[flip];
        wait_ready();
        bus.start = 1'b1;
        if (flip < 7 && model_cnt < 255) model_cnt++;
        e.dout = data;
        e.err  = (flip < 7);
        e.syn  = syn_of(flip);
        e.cnt  = 8'(model_cnt);
        e.cyc  = cyc + 9;
        sb.push_back(e);
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            bus.start = poke && (i == 2);
            bus.din   = cw[i];
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic check_reset();
        check("rst_ready", bus.ready, 1);
        check("rst_done", bus.done, 0);
        check("rst_dout", bus.dout, 0);
        check("rst_err", bus.err, 0);
        check("rst_syndrome", bus.syndrome, 0);
        check("rst_err_count", bus.err_count, 0);
    endtask

    task automatic abort_frame();
        wait_ready();
        bus.start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            bus.din   = 1'($urandom_range(1));
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst       = 1'b1;
        model_cnt = 0;
    endtask

    always @(negedge clk) begin
        if (bus.done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, required 0", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("dout", bus.dout, mon_e.dout);
                check("err", bus.err, mon_e.err);
                check("syndrome", bus.syndrome, mon_e.syn);
                check("err_count", bus.err_count, mon_e.cnt);
                check("done_cycle", cyc, mon_e.cyc);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.din   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        check_reset();

        send_frame(4'b0110, 7, 1'b0);
        send_frame(4'b0110, 4, 1'b0);
        send_frame(4'b0110, 0, 1'b0);

        abort_frame();
        check_reset();
        send_frame(4'b0110, 7, 1'b0);

        for (int d = 0; d < 16; d++) begin
            for (int f = 0; f < 8; f++) begin
                send_frame(4'(d), f, 1'b0);
            end
        end

        for (int i = 0; i < 40; i++) begin
            send_frame(4'($urandom_range(15)), int'($urandom_range(7)), 1'($urandom_range(1)));
        end

        for (int i = 0; i < 260; i++) begin
            send_frame(4'($urandom_range(15)), int'($urandom_range(6)), 1'(i % 2));
        end
        send_frame(4'b1011, 7, 1'b0);
        wait_ready();

        check("err_count_saturated", bus.err_count, 255);
        check("dout_held", bus.dout, 4'b1011);
        check("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hamming_decoding_4bit.md
HAMMING_DECODING_4BIT -- requirements
Module: hamming_decoding_4bit

Interface
REQ-001 The block SHALL have no parameters; widths are fixed at 7-bit codeword and 4-bit data.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous and active-low (rst=0 sampled on a rising clk edge resets the block).
REQ-004 start  input  1  start a codeword reception; sampled only in IDLE.
REQ-005 din  input  1  serial codeword bit, cw[0] first through cw[6] last.
REQ-006 ready  output  1  high exactly when the state is IDLE.
REQ-007 done  output  1  one-cycle pulse; the decoded result is valid.
REQ-008 dout  output  4  corrected data {d3,d2,d1,d0}; registered and held until the next done.
REQ-009 err  output  1  high if the last codeword had a nonzero syndrome and one bit was corrected; held with dout.
REQ-010 syndrome  output  3  syndrome {s2,s1,s0} of the last codeword; held with dout.
REQ-011 err_count  output  8  saturating count of corrected codewords since reset.

Function
REQ-012 Codeword layout SHALL be cw[6:3]=d[3:0], cw[2]=p2, cw[1]=p1, cw[0]=p0, with encoder parity p0=d0^d1^d2, p1=d0^d2^d3, p2=d1^d2^d3.
REQ-013 The FSM SHALL have the states IDLE, RECV, CHECK and DONE.
REQ-014 IDLE->RECV SHALL occur when start=1; otherwise the FSM stays in IDLE.
REQ-015 RECV SHALL last exactly 7 cycles; a 3-bit counter (0..6) SHALL shift din into cw[counter], and the FSM goes to CHECK after counter=6.
REQ-016 CHECK SHALL compute s0=p0^d0^d1^d2, s1=p1^d0^d2^d3, s2=p2^d1^d2^d3 and register the corrected data, err and syndrome; it then goes to DONE.
REQ-017 The syndrome-to-bit correction map SHALL be:
- 001->cw0
- 010->cw1
- 100->cw2
- 011->d0
- 101->d1
- 111->d2
- 110->d3
- 000->no flip, err=0.
REQ-018 Parity-bit errors (syndromes 001/010/100) SHALL set err=1 and leave dout equal to the received data bits.
REQ-019 DONE SHALL assert done=1 for one cycle and go unconditionally to IDLE; a start in DONE is ignored.
REQ-020 Latency SHALL be fixed: start in cycle T, din bits in cycles T+1..T+7, CHECK in T+8, done in T+9, ready again in T+10.
REQ-021 start SHALL be ignored in RECV, CHECK and DONE; back-to-back codewords are possible with start asserted in the first IDLE cycle.
REQ-022 err_count SHALL increment in CHECK when the syndrome is nonzero and saturate at 255 without wrapping.
REQ-023 Double-bit errors are outside the block's correction capability; it SHALL apply the map as-is, with no detection required.

Reset
REQ-024 On reset the block SHALL enter IDLE, with counter=0, cw=0, dout=0, err=0, syndrome=0, err_count=0 and done=0; ready SHALL be 1 on the first cycle after reset.
REQ-025 Reset during RECV or CHECK SHALL discard the partial codeword and produce no done pulse.

Structure
REQ-026 A shared package hamming74_pkg SHALL hold the state encodings, CW_WIDTH=7, DATA_WIDTH=4 and the syndrome constants of REQ-017.
REQ-027 A combinational sub-module hamming74_syndrome SHALL compute the syndrome, corrected data and error flag from a 7-bit cw; the FSM instantiates it once.

Verification
REQ-028 Clean codeword: data 0110, cw=7'b0110010 sent serially as 0,1,0,0,1,1,0 -> done at T+9, dout=0110, err=0, syndrome=000, err_count=0.
REQ-029 Data-bit error: cw[4] flipped (7'b0100010) -> dout=0110, err=1, syndrome=101, err_count=1.
REQ-030 Parity-bit error: cw[0] flipped (7'b0110011) -> dout=0110, err=1, syndrome=001.
REQ-031 Exhaustive sweep: all 16 data values x {no error, each of the 7 single-bit flips} -> dout always equals the original data; the syndrome matches REQ-017.
REQ-032 Reset mid-RECV: rst=0 after 3 bits, then a full clean codeword -> no done for the aborted frame; correct result for the second frame.
REQ-033 Saturation and ignored start: 260 single-error frames -> err_count=255; start pulsed during RECV -> no effect on timing or result.
